// File: rtl/wvb_rd_ctrl_pkg.sv
// Shared definitions for the waveform buffer read controller:
// FSM state encoding, bundle-3 header field placement, length-width relation.
package wvb_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Bundle-3 header layout: [ADR-1:0] stop_addr, [2*ADR-1:ADR] start_addr,
  // remaining upper bits (LTC, trigger info) pass through untouched.
  localparam int B3_STOP_LSB  = 0;
  localparam int B3_START_LSB = 12;

  // Event length must represent 1..2^adr_w, hence one extra bit.
  function automatic int len_width(input int adr_w);
    return adr_w + 1;
  endfunction

endpackage

// File: rtl/wvb_rd_skid.sv
// Two-entry valid/ready buffer absorbing the one-cycle RAM read latency.
// Output beat is held in a register; almost_full is the occupancy after the
// current edge (pushes and pops included) reaching two entries.
module wvb_rd_skid #(
  parameter int P_WIDTH = 24
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               in_valid,
  input  logic [P_WIDTH-1:0] in_data,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] out_data,
  input  logic               out_ready,
  output logic               almost_full
);

  logic               skid_valid;
  logic [P_WIDTH-1:0] skid_data;
  logic               pop;
  logic [1:0]         occ_next;

  assign pop         = out_valid && out_ready;
  assign occ_next    = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, in_valid} - {1'b0, pop};
  assign almost_full = (occ_next >= 2'd2);

  // Refill the output register from the spare entry first, else from the input.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= in_valid;
        if (in_valid) skid_data <= in_data;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/wvb_rd_ctrl.sv
// Waveform buffer read controller: pops one header, reads start..stop from the
// circular buffer RAM (with wrap) and streams samples with sop/eop.
// Optional truncation: define WVB_RD_CTRL_TRUNC_EN to add rd_max_len/dout_trunc.
//
// state   | meaning
// S_IDLE  | waiting for en and a header; pops and latches it
// S_LOAD  | computes evt_len, presents start_addr
// S_READ  | issues one RAM read per cycle while the skid buffer has room
// S_DRAIN | all reads issued; waits for the eop handshake, then releases
module wvb_rd_ctrl
  import wvb_rd_ctrl_pkg::*;
#(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_LEN_WIDTH  = len_width(P_ADR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    en,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic                    hdr_rd_en,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [P_DATA_WIDTH-1:0] dout_data,
  output logic                    dout_sop,
  output logic                    dout_eop,
  output logic [P_HDR_WIDTH-1:0]  dout_hdr,
  output logic [P_LEN_WIDTH-1:0]  evt_len,
  output logic [P_ADR_WIDTH-1:0]  rd_ptr,
  output logic [31:0]             evt_cnt,
  output logic                    busy
`ifdef WVB_RD_CTRL_TRUNC_EN
  ,
  input  logic [P_LEN_WIDTH-1:0]  rd_max_len,
  output logic                    dout_trunc
`endif
);

  state_t                  state;
  logic [P_LEN_WIDTH-1:0]  tgt_len;
  logic [P_LEN_WIDTH-1:0]  issue_cnt;
  logic                    rd_vld_q, rd_sop_q, rd_eop_q;
  logic                    skid_af;
  logic                    issue, last_issue, eop_hs;
  logic [P_ADR_WIDTH-1:0]  start_addr, stop_addr, span;
  logic [P_LEN_WIDTH-1:0]  len_c, tgt_c;

  // Header fields come from the latched header so they stay stable all event.
  assign start_addr = dout_hdr[B3_START_LSB +: P_ADR_WIDTH];
  assign stop_addr  = dout_hdr[B3_STOP_LSB +: P_ADR_WIDTH];
  assign span       = stop_addr - start_addr;
  assign len_c      = P_LEN_WIDTH'(span) + P_LEN_WIDTH'(1);

`ifdef WVB_RD_CTRL_TRUNC_EN
  logic trunc_c;
  assign trunc_c = (rd_max_len != '0) && (len_c > rd_max_len);
  assign tgt_c   = trunc_c ? rd_max_len : len_c;
`else
  assign tgt_c   = len_c;
`endif

  assign issue      = (state == S_READ) && !skid_af;
  assign last_issue = (issue_cnt == tgt_len - P_LEN_WIDTH'(1));
  assign eop_hs     = dout_valid && dout_ready && dout_eop;
  assign busy       = (state != S_IDLE);

  // Sequencer plus read-tag pipeline aligned with the RAM latency.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      hdr_rd_en   <= 1'b0;
      dout_hdr    <= '0;
      wvb_rd_addr <= '0;
      evt_len     <= '0;
      tgt_len     <= '0;
      issue_cnt   <= '0;
      rd_ptr      <= '0;
      evt_cnt     <= '0;
      rd_vld_q    <= 1'b0;
      rd_sop_q    <= 1'b0;
      rd_eop_q    <= 1'b0;
`ifdef WVB_RD_CTRL_TRUNC_EN
      dout_trunc  <= 1'b0;
`endif
    end else begin
      hdr_rd_en <= 1'b0;
      rd_vld_q  <= issue;
      rd_sop_q  <= issue && (issue_cnt == '0);
      rd_eop_q  <= issue && last_issue;
      case (state)
        S_IDLE: begin
          if (en && !hdr_empty) begin
            hdr_rd_en <= 1'b1;
            dout_hdr  <= hdr_data;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          evt_len     <= len_c;
          tgt_len     <= tgt_c;
          wvb_rd_addr <= start_addr;
          issue_cnt   <= '0;
`ifdef WVB_RD_CTRL_TRUNC_EN
          dout_trunc  <= trunc_c;
`endif
          state       <= S_READ;
        end
        S_READ: begin
          if (issue) begin
            wvb_rd_addr <= wvb_rd_addr + P_ADR_WIDTH'(1);
            issue_cnt   <= issue_cnt + P_LEN_WIDTH'(1);
            if (last_issue) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (eop_hs) begin
            rd_ptr     <= stop_addr + P_ADR_WIDTH'(1);
            evt_cnt    <= evt_cnt + 32'd1;
`ifdef WVB_RD_CTRL_TRUNC_EN
            dout_trunc <= 1'b0;
`endif
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  wvb_rd_skid #(
    .P_WIDTH(P_DATA_WIDTH + 2)
  ) u_skid (
    .clk        (clk),
    .i_rst      (i_rst),
    .in_valid   (rd_vld_q),
    .in_data    ({rd_sop_q, rd_eop_q, wvb_rd_data}),
    .out_valid  (dout_valid),
    .out_data   ({dout_sop, dout_eop, dout_data}),
    .out_ready  (dout_ready),
    .almost_full(skid_af)
  );

endmodule
